// File: rtl/arrow_key_decoder.sv
// PS/2 scan-code decoder for the four extended arrow keys: tracks held state
// through the E0/F0 prefix FSM and emits rate-limited step pulses for user_pos_ctl.
module arrow_key_decoder #(
    parameter int STEP_DIV = 650000,
    parameter int TIMEOUT  = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ps2_data,
    input  logic       ps2_valid,
    output logic [3:0] keys,
    output logic [3:0] held,
    output logic       seq_err
);

    localparam int CNT_W = $clog2(STEP_DIV);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        EXT_BRK,
        BRK
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         held_q, held_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               seq_err_q, seq_err_d;
    logic [3:0]         arrow_mask;
    logic               is_err_code;

    // One-hot {U,D,R,L} for an arrow scan code, zero for anything else.
    always_comb begin
        arrow_mask = 4'b0000;
        case (ps2_data)
            8'h75:   arrow_mask = 4'b1000;
            8'h72:   arrow_mask = 4'b0100;
            8'h74:   arrow_mask = 4'b0010;
            8'h6B:   arrow_mask = 4'b0001;
            default: arrow_mask = 4'b0000;
        endcase
    end

    assign is_err_code = (ps2_data == 8'h00) || (ps2_data == 8'hFF);

    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        tmo_d     = tmo_q;
        seq_err_d = 1'b0;

        if (ps2_valid) begin
            tmo_d = '0;
            if (is_err_code) begin
                held_d    = 4'b0000;
                state_d   = IDLE;
                seq_err_d = 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ps2_data == 8'hE0)
                            state_d = EXT;
                        else if (ps2_data == 8'hF0)
                            state_d = BRK;
                    end
                    EXT: begin
                        if (ps2_data == 8'hF0) begin
                            state_d = EXT_BRK;
                        end else begin
                            held_d  = held_q | arrow_mask;
                            state_d = IDLE;
                        end
                    end
                    EXT_BRK: begin
                        held_d  = held_q & ~arrow_mask;
                        state_d = IDLE;
                    end
                    BRK:     state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end else if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            // Abandon the stalled prefix but keep whatever keys are held.
            state_d   = IDLE;
            tmo_d     = '0;
            seq_err_d = 1'b1;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Cadence keeps running across typematic repeats and extra presses.
    always_comb begin
        if (held_q == 4'b0000)
            cnt_d = '0;
        else if (cnt_q == CNT_LAST)
            cnt_d = '0;
        else
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            held_q    <= 4'b0000;
            cnt_q     <= '0;
            tmo_q     <= '0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            held_q    <= held_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign held    = held_q;
    assign seq_err = seq_err_q;
    assign keys    = (cnt_q == '0) ? held_q : 4'b0000;

endmodule

// File: tb/tb_arrow_key_decoder.sv
// Directed bench for arrow_key_decoder (STEP_DIV=4, TIMEOUT=10): each step queues
// the hand-derived held/keys/seq_err expected after the next clock edge.
module tb_arrow_key_decoder;

    logic       clk;
    logic       rst;
    logic [7:0] ps2_data;
    logic       ps2_valid;
    logic [3:0] keys;
    logic [3:0] held;
    logic       seq_err;

    arrow_key_decoder #(
        .STEP_DIV(4),
        .TIMEOUT (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_data (ps2_data),
        .ps2_valid(ps2_valid),
        .keys     (keys),
        .held     (held),
        .seq_err  (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] held;
        logic [3:0] keys;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    localparam logic [3:0] N = 4'b0000;
    localparam logic [3:0] U = 4'b1000;
    localparam logic [3:0] D = 4'b0100;
    localparam logic [3:0] R = 4'b0010;
    localparam logic [3:0] L = 4'b0001;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL step %0d %s: observed %b expected %b", step, tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of input, then compare outputs just after the edge.
    task automatic cyc(input logic v, input logic [7:0] d,
                       input logic [3:0] eh, input logic [3:0] ek, input logic ee);
        exp_t e;
        ps2_valid = v;
        ps2_data  = d;
        sb.push_back('{held: eh, keys: ek, err: ee});
        @(posedge clk);
        #1;
        step++;
        e = sb.pop_front();
        check("held", held, e.held);
        check("keys", keys, e.keys);
        check("seq_err", {3'b000, seq_err}, {3'b000, e.err});
        $display("step %0d: valid=%b data=%h held=%b keys=%b seq_err=%b",
                 step, v, d, held, keys, seq_err);
    endtask

    initial begin
        rst = 1'b1;
        ps2_valid = 1'b0;
        ps2_data = 8'h00;
        cyc(0, 8'h00, N, N, 0);
        cyc(0, 8'h00, N, N, 0);
        rst = 1'b0;

        // Press U: pulse at t1+1, t1+5, t1+9.
        cyc(1, 8'hE0, N, N, 0);
        cyc(1, 8'h75, U, U, 0);
        cyc(0, 8'h00, U, N, 0);
        cyc(0, 8'h00, U, N, 0);
        cyc(0, 8'h00, U, N, 0);
        cyc(0, 8'h00, U, U, 0);
        cyc(0, 8'h00, U, N, 0);
        cyc(0, 8'h00, U, N, 0);
        cyc(0, 8'h00, U, N, 0);
        cyc(0, 8'h00, U, U, 0);

        // Add R: joins existing cadence.
        cyc(1, 8'hE0, U, N, 0);
        cyc(1, 8'h74, U | R, N, 0);
        cyc(0, 8'h00, U | R, N, 0);
        cyc(0, 8'h00, U | R, U | R, 0);
        // Release U.
        cyc(1, 8'hE0, U | R, N, 0);
        cyc(1, 8'hF0, U | R, N, 0);
        cyc(1, 8'h75, R, N, 0);
        cyc(0, 8'h00, R, R, 0);
        // Release R landing where cnt would be 0: no pulse.
        cyc(0, 8'h00, R, N, 0);
        cyc(1, 8'hE0, R, N, 0);
        cyc(1, 8'hF0, R, N, 0);
        cyc(1, 8'h74, N, N, 0);
        cyc(0, 8'h00, N, N, 0);
        // Break for a key that is not held.
        cyc(1, 8'hE0, N, N, 0);
        cyc(1, 8'hF0, N, N, 0);
        cyc(1, 8'h6B, N, N, 0);

        // New press starts fresh cadence; typematic repeat does not restart it.
        cyc(1, 8'hE0, N, N, 0);
        cyc(1, 8'h75, U, U, 0);
        cyc(0, 8'h00, U, N, 0);
        cyc(1, 8'hE0, U, N, 0);
        cyc(1, 8'h75, U, N, 0);
        cyc(0, 8'h00, U, U, 0);
        // Non-extended break F0 75 leaves U held; bare 74 then ignored in IDLE.
        cyc(1, 8'hF0, U, N, 0);
        cyc(1, 8'h75, U, N, 0);
        cyc(0, 8'h00, U, N, 0);
        cyc(1, 8'h74, U, U, 0);
        cyc(1, 8'hE0, U, N, 0);
        cyc(1, 8'hF0, U, N, 0);
        cyc(1, 8'h75, N, N, 0);

        // Timeout after E0: seq_err on the 10th idle cycle, then 75 alone ignored.
        cyc(1, 8'hE0, N, N, 0);
        for (int i = 0; i < 9; i++) cyc(0, 8'h00, N, N, 0);
        cyc(0, 8'h00, N, N, 1);
        cyc(1, 8'h75, N, N, 0);
        cyc(0, 8'h00, N, N, 0);

        // Byte arriving on the timeout cycle wins.
        cyc(1, 8'hE0, N, N, 0);
        for (int i = 0; i < 9; i++) cyc(0, 8'h00, N, N, 0);
        cyc(1, 8'h75, U, U, 0);

        // Build held=0101, then error code FF clears all.
        cyc(1, 8'hE0, U, N, 0);
        cyc(1, 8'h72, U | D, N, 0);
        cyc(1, 8'hE0, U | D, N, 0);
        cyc(1, 8'h6B, U | D | L, U | D | L, 0);
        cyc(1, 8'hE0, U | D | L, N, 0);
        cyc(1, 8'hF0, U | D | L, N, 0);
        cyc(1, 8'h75, D | L, N, 0);
        cyc(1, 8'hFF, N, N, 1);
        cyc(0, 8'h00, N, N, 0);
        // Error code 00 inside a prefix.
        cyc(1, 8'hE0, N, N, 0);
        cyc(1, 8'h00, N, N, 1);
        cyc(0, 8'h00, N, N, 0);

        // Reset mid-sequence after E0 F0 with U held.
        cyc(1, 8'hE0, N, N, 0);
        cyc(1, 8'h75, U, U, 0);
        cyc(1, 8'hE0, U, N, 0);
        cyc(1, 8'hF0, U, N, 0);
        rst = 1'b1;
        cyc(0, 8'h00, N, N, 0);
        rst = 1'b0;
        cyc(1, 8'h75, N, N, 0);
        cyc(0, 8'h00, N, N, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
